mag11_arb: RTL and testbench



---
 rtl/mag11_arb_pkg.sv | 23 ++
 rtl/mag11_rr_pick.sv | 36 +++
 rtl/mag11_arb.sv | 92 +++++++++
 tb/tb_mag11_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mag11_arb_pkg.sv
// mag11_arb_pkg: shared constants and result record for the mag11_arb comparator arbiter.
// Optional build macro used by this slice: MAG11_ARB_PRIO0_EN (requester 0 precedence).
package mag11_arb_pkg;

    localparam int MAG_W    = 11;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                agb;
        logic                aeb;
        logic                alb;
    } rsp_t;

    localparam rsp_t RSP_RST = '0;

    // Pointer value out of reset: the last slot, so requester 0 is searched first.
    function automatic int rst_last(input int nreq);
        return nreq - 1;
    endfunction

endpackage

// File: rtl/mag11_rr_pick.sv
// mag11_rr_pick: combinational round-robin picker, search starts one past `last`.
// With MAG11_ARB_PRIO0_EN defined, requester 0 overrides the rotation whenever it asks.
module mag11_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  win,
    output logic            any
);

    always_comb begin
        int idx;
        gnt = '0;
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = IDW'(idx);
            end
        end
`ifdef MAG11_ARB_PRIO0_EN
        if (req[0]) begin
            any = 1'b1;
            win = '0;
        end
`endif
        if (any) gnt[win] = 1'b1;
    end

endmodule

// File: rtl/mag11_arb.sv
// mag11_arb: round-robin sharing of one 11-bit magnitude comparator, result two cycles after grant.
// Build option MAG11_ARB_PRIO0_EN gives requester 0 absolute precedence.
module mag11_arb
    import mag11_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  sys_clk,
    input  logic                  resetl,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*MAG_W-1:0] a_in,
    input  logic [NREQ*MAG_W-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic                  agb,
    output logic                  aeb,
    output logic                  alb
);

    logic [NREQ-1:0]  pick_gnt;
    logic [IDW-1:0]   win;
    logic             any;
    logic [IDW-1:0]   last_q, last_d;
    logic             s1_valid_q, s1_valid_d;
    logic [MAG_W-1:0] s1_a_q, s1_a_d;
    logic [MAG_W-1:0] s1_b_q, s1_b_d;
    logic [IDW-1:0]   s1_id_q, s1_id_d;
    rsp_t             out_q, out_d;

    mag11_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (pick_gnt),
        .win  (win),
        .any  (any)
    );

    always_comb begin
        gnt        = resetl ? pick_gnt : '0;
        s1_valid_d = any;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        last_d     = last_q;
        if (any) begin
            s1_a_d  = a_in[int'(win)*MAG_W +: MAG_W];
            s1_b_d  = b_in[int'(win)*MAG_W +: MAG_W];
            s1_id_d = win;
`ifdef MAG11_ARB_PRIO0_EN
            last_d  = (win == '0) ? last_q : win;
`else
            last_d  = win;
`endif
        end
        // The single shared comparator; flags and id hold between valid results.
        out_d       = out_q;
        out_d.valid = s1_valid_q;
        if (s1_valid_q) begin
            out_d.id  = ID_MAX_W'(s1_id_q);
            out_d.agb = s1_a_q > s1_b_q;
            out_d.aeb = s1_a_q == s1_b_q;
            out_d.alb = s1_a_q < s1_b_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            last_q     <= IDW'(rst_last(NREQ));
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            out_q      <= RSP_RST;
        end else begin
            last_q     <= last_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            out_q      <= out_d;
        end
    end

    assign rsp_valid = out_q.valid;
    assign rsp_id    = out_q.id[IDW-1:0];
    assign agb       = out_q.agb;
    assign aeb       = out_q.aeb;
    assign alb       = out_q.alb;

endmodule

// File: tb/tb_mag11_arb.sv
// tb_mag11_arb: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_mag11_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              sys_clk = 1'b0;
    logic              resetl  = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [NREQ*11-1:0] a_in   = '0;
    logic [NREQ*11-1:0] b_in   = '0;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic              agb, aeb, alb;

    mag11_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .sys_clk   (sys_clk),
        .resetl    (resetl),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .agb       (agb),
        .aeb       (aeb),
        .alb       (alb)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: pending compares waiting for their due cycle.
    typedef struct { int due; int id; int a; int b; } pend_t;
    pend_t pq[$];
    int m_last = NREQ - 1;
    int cyc = 0;
    int exp_v = 0, h_id = 0, h_agb = 0, h_aeb = 0, h_alb = 0;

    function automatic int m_pick(input logic [NREQ-1:0] r);
`ifdef MAG11_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++)
            if (r[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        return -1;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*11 +: 11] = 11'(a);
        b_in[i*11 +: 11] = 11'(b);
    endtask

    // One model-checked clock: grant before the edge, response state after it.
    task automatic mcycle();
        int w;
        pend_t p;
        #1;
        w = resetl ? m_pick(req) : -1;
        chk("gnt", int'(gnt), w < 0 ? 0 : (1 << w));
        if (w >= 0) begin
            pq.push_back('{cyc + 2, w, int'(a_in[w*11 +: 11]), int'(b_in[w*11 +: 11])});
`ifdef MAG11_ARB_PRIO0_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
        end
        @(posedge sys_clk);
        cyc++;
        exp_v = 0;
        if (!resetl) begin
            pq.delete();
            m_last = NREQ - 1;
            {h_id, h_agb, h_aeb, h_alb} = '0;
        end else if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            exp_v = 1;
            h_id  = p.id;
            h_agb = int'(p.a > p.b);
            h_aeb = int'(p.a == p.b);
            h_alb = int'(p.a < p.b);
        end
        #1;
        chk("rsp_valid", int'(rsp_valid), exp_v);
        chk("rsp_id", int'(rsp_id), h_id);
        chk("agb", int'(agb), h_agb);
        chk("aeb", int'(aeb), h_aeb);
        chk("alb", int'(alb), h_alb);
    endtask

    typedef struct { int id; int a; int b; logic [3:0] egnt; logic [2:0] eflags; } vec_t;
    vec_t vt[8];

    initial begin
        vt[0] = '{2, 1500, 1024, 4'b0100, 3'b100};
        vt[1] = '{0,    0, 2047, 4'b0001, 3'b001};
        vt[2] = '{1, 2047, 2047, 4'b0010, 3'b010};
        vt[3] = '{3, 2047,    0, 4'b1000, 3'b100};
        vt[4] = '{0,    5,    5, 4'b0001, 3'b010};
        vt[5] = '{3, 1023, 1024, 4'b1000, 3'b001};
        vt[6] = '{1, 1024, 1023, 4'b0010, 3'b100};
        vt[7] = '{2,    0,    0, 4'b0100, 3'b010};

        @(posedge sys_clk);
        #1;
        // Reset held with everyone requesting.
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_gnt", int'(gnt), 0);
            mcycle();
            chk("rst_flags", int'({rsp_valid, agb, aeb, alb}), 0);
        end
        resetl = 1'b1;
        #1;
        chk("first_gnt", int'(gnt), 1);
        req = '0;
        mcycle();
        mcycle();

        // Vector table: isolated single-requester compares.
        foreach (vt[r]) begin
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom_range(2047), $urandom_range(2047));
            set_op(vt[r].id, vt[r].a, vt[r].b);
            req = vt[r].egnt;
            #1;
            chk("vec_gnt", int'(gnt), int'(vt[r].egnt));
            mcycle();
            req = '0;
            mcycle();
            chk("vec_valid", int'(rsp_valid), 1);
            chk("vec_id", int'(rsp_id), vt[r].id);
            chk("vec_flags", int'({agb, aeb, alb}), int'(vt[r].eflags));
        end

        // Full contention from a fresh reset, a=b=i.
        resetl = 1'b0;
        mcycle();
        resetl = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i, i);
        for (int k = 0; k < 10; k++) begin
            req = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
`ifdef MAG11_ARB_PRIO0_EN
            chk("rot_gnt", int'(gnt), k < 8 ? 1 : 0);
`else
            chk("rot_gnt", int'(gnt), k < 8 ? (1 << (k % 4)) : 0);
`endif
            mcycle();
            if (k >= 1 && k <= 8) begin
                chk("rot_valid", int'(rsp_valid), 1);
`ifdef MAG11_ARB_PRIO0_EN
                chk("rot_id", int'(rsp_id), 0);
`else
                chk("rot_id", int'(rsp_id), (k - 1) % 4);
`endif
                chk("rot_aeb", int'(aeb), 1);
            end
        end

        // Reset one edge after a grant: the result must never appear.
        mcycle();
        set_op(2, 100, 50);
        req = 4'b0100;
        mcycle();
        resetl = 1'b0;
        req = '0;
        mcycle();
        chk("mid_valid1", int'(rsp_valid), 0);
        resetl = 1'b1;
        mcycle();
        chk("mid_valid2", int'(rsp_valid), 0);
        chk("mid_agb", int'(agb), 0);
        req = 4'b1111;
        #1;
        chk("mid_restart", int'(gnt), 1);
        mcycle();
        req = '0;
        mcycle();
        mcycle();

`ifdef MAG11_ARB_PRIO0_EN
        resetl = 1'b0;
        mcycle();
        resetl = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("prio_gnt", int'(gnt), 1);
            mcycle();
        end
        req = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("prio_rot", int'(gnt), 2 << (k % 3));
            mcycle();
        end
`endif

        // Random traffic, boundary operands mixed in, occasional reset.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                case ($urandom_range(3))
                    0: set_op(i, 0, 2047);
                    1: set_op(i, 2047, $urandom_range(1) * 2047);
                    default: set_op(i, $urandom_range(2047), $urandom_range(2047));
                endcase
            req    = NREQ'($urandom);
            resetl = ($urandom_range(39) != 0);
            mcycle();
        end
        resetl = 1'b1;
        req = '0;
        mcycle();
        mcycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
